// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-wide RAM arbiter.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IF_RD,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_DONE
    } arb_state_t;

    // Who owns the current transaction; decides which done/data port pulses.
    typedef enum logic [1:0] {
        OWN_IF,
        OWN_MEM_RD,
        OWN_MEM_WR
    } arb_owner_t;

    localparam logic [2:0]  MEM_LEN_BYTE = 3'd1;
    localparam logic [2:0]  MEM_LEN_HALF = 3'd2;
    localparam logic [2:0]  MEM_LEN_WORD = 3'd4;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

    // Only byte, half and word transfers exist; any other encoding is a word.
    function automatic logic [2:0] decode_len(input logic [2:0] len);
        case (len)
            MEM_LEN_BYTE: decode_len = MEM_LEN_BYTE;
            MEM_LEN_HALF: decode_len = MEM_LEN_HALF;
            default:      decode_len = MEM_LEN_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, flush and RAM-port signals of the arbiter, bundled as one interface.
// slave is the arbiter's view; master is the view of the pipeline and RAM around it.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int RAM_AW = 17
);
    logic              flush_i;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [31:0]       if_inst_o;
    logic              if_done_o;
    logic              if_stall_req_o;
    logic              mem_req_i;
    logic              mem_we_i;
    logic [2:0]        mem_len_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [31:0]       mem_wdata_i;
    logic [31:0]       mem_rdata_o;
    logic              mem_done_o;
    logic              mem_stall_req_o;
    logic [RAM_AW-1:0] ram_addr_o;
    logic [7:0]        ram_dout_o;
    logic              ram_wr_o;
    logic [7:0]        ram_din_i;

    modport slave (
        input  flush_i, if_req_i, if_addr_i,
        input  mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
        input  ram_din_i,
        output if_inst_o, if_done_o, if_stall_req_o,
        output mem_rdata_o, mem_done_o, mem_stall_req_o,
        output ram_addr_o, ram_dout_o, ram_wr_o
    );

    modport master (
        output flush_i, if_req_i, if_addr_i,
        output mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
        output ram_din_i,
        input  if_inst_o, if_done_o, if_stall_req_o,
        input  mem_rdata_o, mem_done_o, mem_stall_req_o,
        input  ram_addr_o, ram_dout_o, ram_wr_o
    );

endinterface

// File: rtl/mem_byte_seq.sv
// Byte sequencer: counts bytes of a transaction, forms the RAM address,
// assembles read bytes little-endian and selects the outgoing store byte.
module mem_byte_seq #(
    parameter int RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [2:0]        load_len,
    input  logic [RAM_AW-1:0] load_addr,
    input  logic [31:0]       load_word,
    input  logic              advance,
    input  logic              capture,
    input  logic [7:0]        din,
    output logic [2:0]        cnt,
    output logic [2:0]        len,
    output logic [RAM_AW-1:0] addr,
    output logic [7:0]        wbyte,
    output logic [31:0]       word
);

    logic [RAM_AW-1:0] base;
    logic [1:0]        cap_idx;

    // Byte counter restarts on every grant and steps once per transfer cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 3'd0;
        end else if (load) begin
            cnt <= 3'd0;
        end else if (advance) begin
            cnt <= cnt + 3'd1;
        end
    end

    // Base address and byte count are latched once at grant.
    always_ff @(posedge clk) begin
        if (load) begin
            base <= load_addr;
            len  <= load_len;
        end
    end

    // Word register: store data at grant (zero for reads), then read bytes
    // land one cycle behind their address, hence the cnt-1 slot.
    always_ff @(posedge clk) begin
        if (load) begin
            word <= load_word;
        end else if (capture) begin
            word[{cap_idx, 3'b000} +: 8] <= din;
        end
    end

    assign cap_idx = cnt[1:0] - 2'd1;
    // RAM_AW-bit addition wraps the address at the top of the RAM.
    assign addr    = base + RAM_AW'(cnt);
    assign wbyte   = word[{cnt[1:0], 3'b000} +: 8];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the byte-wide RAM port between instruction fetch and the
// load/store unit; MEM wins ties, transactions run to completion unless an
// IF fetch is flushed or the block is reset.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RAM_AW = 17
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    arb_state_t        state;
    arb_owner_t        owner;
    logic              grant_mem;
    logic              grant_if;
    logic              load;
    logic              rd_state;
    logic              advance;
    logic              capture;
    logic              issue;
    logic              if_done;
    logic              mem_done;
    logic              ram_wr;
    logic [2:0]        load_len;
    logic [RAM_AW-1:0] load_addr;
    logic [31:0]       load_word;
    logic [2:0]        cnt;
    logic [2:0]        len;
    logic [RAM_AW-1:0] seq_addr;
    logic [7:0]        wbyte;
    logic [31:0]       word;
    logic              unused_addr_hi;

    // Grants happen only in IDLE; a flush that cycle suppresses an IF grant only.
    assign grant_mem = (state == ST_IDLE) && bus.mem_req_i;
    assign grant_if  = (state == ST_IDLE) && !bus.mem_req_i && bus.if_req_i && !bus.flush_i;
    assign load      = grant_mem || grant_if;
    assign load_len  = grant_mem ? decode_len(bus.mem_len_i) : MEM_LEN_WORD;
    assign load_addr = grant_mem ? bus.mem_addr_i[RAM_AW-1:0] : bus.if_addr_i[RAM_AW-1:0];
    assign load_word = (grant_mem && bus.mem_we_i) ? bus.mem_wdata_i : ZERO_WORD;

    // Reads spend one extra cycle after the last address collecting the final byte.
    assign rd_state  = (state == ST_IF_RD) || (state == ST_MEM_RD);
    assign advance   = rd_state || (state == ST_MEM_WR);
    assign capture   = rd_state && (cnt != 3'd0);
    assign issue     = (rd_state && (cnt < len)) || (state == ST_MEM_WR);

    assign unused_addr_hi = ^{bus.if_addr_i[ADDR_W-1:RAM_AW], bus.mem_addr_i[ADDR_W-1:RAM_AW]};

    mem_byte_seq #(
        .RAM_AW (RAM_AW)
    ) u_seq (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_len  (load_len),
        .load_addr (load_addr),
        .load_word (load_word),
        .advance   (advance),
        .capture   (capture),
        .din       (bus.ram_din_i),
        .cnt       (cnt),
        .len       (len),
        .addr      (seq_addr),
        .wbyte     (wbyte),
        .word      (word)
    );

    // Transaction FSM: grant, byte issue/collect, one-cycle DONE, back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            owner <= OWN_IF;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_mem) begin
                        state <= bus.mem_we_i ? ST_MEM_WR : ST_MEM_RD;
                        owner <= bus.mem_we_i ? OWN_MEM_WR : OWN_MEM_RD;
                    end else if (grant_if) begin
                        state <= ST_IF_RD;
                        owner <= OWN_IF;
                    end
                end
                ST_IF_RD: begin
                    if (bus.flush_i) begin
                        state <= ST_IDLE;
                    end else if (cnt == len) begin
                        state <= ST_DONE;
                    end
                end
                ST_MEM_RD: begin
                    if (cnt == len) begin
                        state <= ST_DONE;
                    end
                end
                ST_MEM_WR: begin
                    if (cnt == len - 3'd1) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram_wr   = (state == ST_MEM_WR);
    assign if_done  = (state == ST_DONE) && (owner == OWN_IF);
    assign mem_done = (state == ST_DONE) && (owner != OWN_IF);

    assign bus.ram_addr_o      = issue ? seq_addr : '0;
    assign bus.ram_wr_o        = ram_wr;
    assign bus.ram_dout_o      = ram_wr ? wbyte : 8'h00;
    assign bus.if_done_o       = if_done;
    assign bus.mem_done_o      = mem_done;
    assign bus.if_inst_o       = if_done ? word : ZERO_WORD;
    assign bus.mem_rdata_o     = (mem_done && (owner == OWN_MEM_RD)) ? word : ZERO_WORD;
    assign bus.if_stall_req_o  = bus.if_req_i && !if_done;
    assign bus.mem_stall_req_o = bus.mem_req_i && !mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of load/store vectors plus
// cycle-by-cycle sequences for fetch, priority, flush, reset and wrap cases.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int RAM_AW = 17;

    typedef struct {
        logic        we;
        logic [2:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [7:0] ram [0:(1<<RAM_AW)-1];
    vec_t vecs [12];

    mem_arbiter_if #(.ADDR_W(ADDR_W), .RAM_AW(RAM_AW)) ifc ();

    mem_arbiter #(.ADDR_W(ADDR_W), .RAM_AW(RAM_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    // Byte RAM: read data appears the cycle after the address, writes on the edge.
    always @(posedge clk) begin
        ifc.ram_din_i <= ram[ifc.ram_addr_o];
        if (ifc.ram_wr_o) ram[ifc.ram_addr_o] = ifc.ram_dout_o;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ram_word(input logic [RAM_AW-1:0] a);
        return {ram[a + 17'd3], ram[a + 17'd2], ram[a + 17'd1], ram[a]};
    endfunction

    task automatic idle_inputs();
        ifc.flush_i     = 1'b0;
        ifc.if_req_i    = 1'b0;
        ifc.if_addr_i   = '0;
        ifc.mem_req_i   = 1'b0;
        ifc.mem_we_i    = 1'b0;
        ifc.mem_len_i   = 3'd0;
        ifc.mem_addr_i  = '0;
        ifc.mem_wdata_i = '0;
    endtask

    task automatic drive_mem(input logic we, input logic [2:0] len,
                             input logic [31:0] addr, input logic [31:0] wdata);
        ifc.mem_req_i   = 1'b1;
        ifc.mem_we_i    = we;
        ifc.mem_len_i   = len;
        ifc.mem_addr_i  = addr;
        ifc.mem_wdata_i = wdata;
    endtask

    initial begin
        logic [63:0] e;
        logic [31:0] wd;

        for (int i = 0; i < (1<<RAM_AW); i++) ram[i] = 8'h00;
        ram[17'h100] = 8'h13; ram[17'h101] = 8'h05; ram[17'h102] = 8'h10; ram[17'h103] = 8'h00;
        ram[17'h300] = 8'h80;
        ram[17'h400] = 8'h11; ram[17'h401] = 8'h22; ram[17'h402] = 8'h33; ram[17'h403] = 8'h44;

        vecs[0]  = '{we:1'b0, len:3'd1, addr:32'h0000_0300, wdata:32'h0,         exp_data:32'h0000_0080, exp_lat:3};
        vecs[1]  = '{we:1'b0, len:3'd2, addr:32'h0000_0402, wdata:32'h0,         exp_data:32'h0000_4433, exp_lat:4};
        vecs[2]  = '{we:1'b0, len:3'd4, addr:32'hFFFE_0400, wdata:32'h0,         exp_data:32'h4433_2211, exp_lat:6};
        vecs[3]  = '{we:1'b0, len:3'd3, addr:32'h0000_0400, wdata:32'h0,         exp_data:32'h4433_2211, exp_lat:6};
        vecs[4]  = '{we:1'b1, len:3'd1, addr:32'h0000_0500, wdata:32'hAABB_CCDD, exp_data:32'h0000_00DD, exp_lat:2};
        vecs[5]  = '{we:1'b1, len:3'd2, addr:32'h0000_0510, wdata:32'h1122_3344, exp_data:32'h0000_3344, exp_lat:3};
        vecs[6]  = '{we:1'b1, len:3'd4, addr:32'h0000_0520, wdata:32'hCAFE_F00D, exp_data:32'hCAFE_F00D, exp_lat:5};
        vecs[7]  = '{we:1'b0, len:3'd4, addr:32'h0000_0520, wdata:32'h0,         exp_data:32'hCAFE_F00D, exp_lat:6};
        vecs[8]  = '{we:1'b0, len:3'd0, addr:32'h0000_0100, wdata:32'h0,         exp_data:32'h0010_0513, exp_lat:6};
        vecs[9]  = '{we:1'b1, len:3'd2, addr:32'h0001_FFFF, wdata:32'h0000_1234, exp_data:32'h0000_1234, exp_lat:3};
        vecs[10] = '{we:1'b0, len:3'd7, addr:32'h0001_FFFF, wdata:32'h0,         exp_data:32'h0000_1234, exp_lat:6};
        vecs[11] = '{we:1'b1, len:3'd6, addr:32'h0000_0700, wdata:32'h5566_7788, exp_data:32'h5566_7788, exp_lat:5};

        // Reset state
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {ifc.ram_addr_o, ifc.ram_dout_o, ifc.ram_wr_o, ifc.if_done_o, ifc.mem_done_o}, 64'h0);
        check("reset_data", {ifc.if_inst_o, ifc.mem_rdata_o}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Seq 1: word fetch from 0x100
        @(posedge clk); #1;
        ifc.if_req_i = 1'b1; ifc.if_addr_i = 32'h100;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            e = (c >= 1 && c <= 4) ? 64'h100 + 64'(c - 1) : 64'h0;
            check($sformatf("s1_addr_c%0d", c), ifc.ram_addr_o, e);
            check($sformatf("s1_stall_c%0d", c), ifc.if_stall_req_o, c < 6);
            check($sformatf("s1_done_c%0d", c), ifc.if_done_o, c == 6);
            if (c == 6) check("s1_inst", ifc.if_inst_o, 32'h0010_0513);
            @(posedge clk); #1;
        end
        ifc.if_req_i = 1'b0;

        // Seq 2: store word 0xDEADBEEF at 0x200
        wd = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        drive_mem(1'b1, 3'd4, 32'h200, wd);
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            e = (c >= 1 && c <= 4) ? 64'h200 + 64'(c - 1) : 64'h0;
            check($sformatf("s2_addr_c%0d", c), ifc.ram_addr_o, e);
            check($sformatf("s2_wr_c%0d", c), ifc.ram_wr_o, c >= 1 && c <= 4);
            if (c >= 1 && c <= 4) check($sformatf("s2_dout_c%0d", c), ifc.ram_dout_o, wd[8*(c-1) +: 8]);
            check($sformatf("s2_done_c%0d", c), ifc.mem_done_o, c == 5);
            @(posedge clk); #1;
        end
        idle_inputs();
        check("s2_ram", ram_word(17'h200), 32'hDEAD_BEEF);

        // Seq 3: simultaneous load byte and fetch, MEM first
        @(posedge clk); #1;
        drive_mem(1'b0, 3'd1, 32'h300, 32'h0);
        ifc.if_req_i = 1'b1; ifc.if_addr_i = 32'h100;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            check($sformatf("s3_mdone_c%0d", c), ifc.mem_done_o, c == 3);
            if (c == 3) check("s3_rdata", ifc.mem_rdata_o, 32'h0000_0080);
            if (c == 5) check("s3_if_addr", ifc.ram_addr_o, 17'h100);
            check($sformatf("s3_idone_c%0d", c), ifc.if_done_o, c == 10);
            if (c == 10) check("s3_inst", ifc.if_inst_o, 32'h0010_0513);
            @(posedge clk); #1;
            if (c == 3) ifc.mem_req_i = 1'b0;
            if (c == 10) ifc.if_req_i = 1'b0;
        end

        // Seq 4: flush aborts a fetch, new PC granted right after
        @(posedge clk); #1;
        ifc.if_req_i = 1'b1; ifc.if_addr_i = 32'h100;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c == 4) check("s4_no_addr", ifc.ram_addr_o, 17'h0);
            if (c == 5) check("s4_new_addr", ifc.ram_addr_o, 17'h400);
            check($sformatf("s4_idone_c%0d", c), ifc.if_done_o, c == 10);
            if (c == 10) check("s4_inst", ifc.if_inst_o, 32'h4433_2211);
            @(posedge clk); #1;
            if (c == 2) begin ifc.flush_i = 1'b1; ifc.if_addr_i = 32'h400; end
            if (c == 3) ifc.flush_i = 1'b0;
            if (c == 10) ifc.if_req_i = 1'b0;
        end

        // Seq 5: store half at top of RAM interrupted by reset
        @(posedge clk); #1;
        drive_mem(1'b1, 3'd2, 32'h1FFFF, 32'h1234);
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("s5_addr", ifc.ram_addr_o, 17'h1FFFF);
                check("s5_wr", ifc.ram_wr_o, 1'b1);
                check("s5_dout", ifc.ram_dout_o, 8'h34);
            end
            if (c >= 3) begin
                check($sformatf("s5_wr_c%0d", c), ifc.ram_wr_o, 1'b0);
                check($sformatf("s5_done_c%0d", c), ifc.mem_done_o, 1'b0);
            end
            @(posedge clk); #1;
            if (c == 1) begin rst = 1'b1; idle_inputs(); end
            if (c == 2) rst = 1'b0;
        end
        check("s5_ram_top", ram[17'h1FFFF], 8'h34);
        ram[17'h1FFFF] = 8'h00;
        ram[17'h00000] = 8'h00;

        // Seq 6: flush during a word store does not cut it short
        wd = 32'h0102_0304;
        @(posedge clk); #1;
        drive_mem(1'b1, 3'd4, 32'h600, wd);
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("s6_wr_c%0d", c), ifc.ram_wr_o, c >= 1 && c <= 4);
            check($sformatf("s6_done_c%0d", c), ifc.mem_done_o, c == 5);
            @(posedge clk); #1;
            if (c == 1) ifc.flush_i = 1'b1;
            if (c == 3) ifc.flush_i = 1'b0;
        end
        idle_inputs();
        check("s6_ram", ram_word(17'h600), 32'h0102_0304);

        // Seq 7: flush in IDLE holds off the fetch grant for that cycle
        @(posedge clk); #1;
        ifc.if_req_i = 1'b1; ifc.if_addr_i = 32'h400; ifc.flush_i = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) check("s7_no_grant", ifc.ram_addr_o, 17'h0);
            if (c == 2) check("s7_addr", ifc.ram_addr_o, 17'h400);
            check($sformatf("s7_idone_c%0d", c), ifc.if_done_o, c == 7);
            if (c == 7) check("s7_inst", ifc.if_inst_o, 32'h4433_2211);
            @(posedge clk); #1;
            if (c == 0) ifc.flush_i = 1'b0;
            if (c == 7) ifc.if_req_i = 1'b0;
        end

        // Table of load/store vectors: latency from grant to done, then data
        for (int v = 0; v < 12; v++) begin
            int          c;
            logic        got;
            logic [31:0] rd;
            @(posedge clk); #1;
            drive_mem(vecs[v].we, vecs[v].len, vecs[v].addr, vecs[v].wdata);
            c   = 0;
            got = 1'b0;
            rd  = 32'h0;
            while (!got && c < 20) begin
                @(negedge clk);
                if (ifc.mem_done_o) begin
                    got = 1'b1;
                    rd  = ifc.mem_rdata_o;
                end else begin
                    c++;
                end
            end
            @(posedge clk); #1;
            idle_inputs();
            check($sformatf("vec%0d_latency", v), 64'(c), 64'(vecs[v].exp_lat));
            if (vecs[v].we)
                check($sformatf("vec%0d_ram", v), ram_word(vecs[v].addr[RAM_AW-1:0]), vecs[v].exp_data);
            else
                check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_data);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
